// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch BCD digit chain.
// mod_of extracts the modulus of one digit from a packed nibble vector.
package stopwatch_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam int SW_MAX_DIGITS = 8;

   // MM:SS ordering, digit 0 in the low nibble: sec units, sec tens, min units, min tens.
   localparam logic [15:0] SW_MMSS_MODS = {4'd6, 4'd10, 4'd6, 4'd10};

   function automatic bcd_digit_t mod_of(input logic [4*SW_MAX_DIGITS-1:0] mods, input int i);
      return mods[4*i +: 4];
   endfunction

endpackage

// File: rtl/bcd_mod_digit.sv
// Single BCD digit counter with a configurable modulus.
// The step input already includes the chain carry/borrow and the count tick.
module bcd_mod_digit
   import stopwatch_pkg::*;
#(
   parameter int MOD = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   input  logic       up_dn,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] load_d,
   output logic [3:0] q,
   output logic       at_max,
   output logic       at_zero
);

   localparam bcd_digit_t MAX_V = bcd_digit_t'(MOD - 1);

   bcd_digit_t r_q;
   bcd_digit_t w_next;

   assign at_max  = (r_q == MAX_V);
   assign at_zero = (r_q == 4'd0);
   assign q       = r_q;

   always_comb begin
      w_next = r_q;
      if (clr) begin
         w_next = '0;
      end else if (load) begin
         // Out-of-range load values collapse to zero rather than being clamped.
         w_next = (load_d <= MAX_V) ? load_d : '0;
      end else if (step) begin
         if (up_dn) begin
            w_next = at_max ? '0 : r_q + 4'd1;
         end else begin
            w_next = at_zero ? MAX_V : r_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         r_q <= w_next;
      end
   end

endmodule

// File: rtl/stopwatch_bcd_chain.sv
// Cascade of per-modulus BCD digits with direction, clear, load, lap hold and wrap pulse.
// Carry and borrow are combinational prefix-ANDs, so every digit updates on the same edge.
module stopwatch_bcd_chain
   import stopwatch_pkg::*;
#(
   parameter int                        NUM_DIGITS = 4,
   parameter logic [4*NUM_DIGITS-1:0]   DIGIT_MODS = SW_MMSS_MODS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      clr,
   input  logic                      up_dn,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   load_val,
   input  logic                      lap,
   output logic [4*NUM_DIGITS-1:0]   digits,
   output logic [4*NUM_DIGITS-1:0]   disp,
   output logic                      holding,
   output logic                      wrap
);

   localparam int W = 4 * NUM_DIGITS;

   logic [NUM_DIGITS:0]   w_carry;
   logic [NUM_DIGITS:0]   w_borrow;
   logic [NUM_DIGITS-1:0] w_at_max;
   logic [NUM_DIGITS-1:0] w_at_zero;
   logic [NUM_DIGITS-1:0] w_step;
   logic [W-1:0]          w_digits;
   logic                  w_wrap_next;
   logic                  w_lap_set;

   logic [W-1:0]          r_lap_q;
   logic                  r_lap_pend;
   logic                  r_holding;
   logic                  r_wrap;

   assign w_carry[0]  = 1'b1;
   assign w_borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         localparam int MOD_I = int'(mod_of((4*SW_MAX_DIGITS)'(DIGIT_MODS), gi));

         assign w_carry[gi+1]  = w_carry[gi]  & w_at_max[gi];
         assign w_borrow[gi+1] = w_borrow[gi] & w_at_zero[gi];
         assign w_step[gi]     = en & (up_dn ? w_carry[gi] : w_borrow[gi]);

         bcd_mod_digit #(
            .MOD (MOD_I)
         ) u_digit (
            .clk     (clk),
            .reset   (reset),
            .step    (w_step[gi]),
            .up_dn   (up_dn),
            .clr     (clr),
            .load    (load),
            .load_d  (load_val[4*gi +: 4]),
            .q       (w_digits[4*gi +: 4]),
            .at_max  (w_at_max[gi]),
            .at_zero (w_at_zero[gi])
         );
      end
   endgenerate

   // A full carry/borrow out of the top digit is exactly the whole-chain wrap.
   assign w_wrap_next = en & ~clr & ~load &
                        (up_dn ? w_carry[NUM_DIGITS] : w_borrow[NUM_DIGITS]);
   assign w_lap_set   = lap & ~r_holding & ~clr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrap     <= 1'b0;
         r_holding  <= 1'b0;
         r_lap_pend <= 1'b0;
         r_lap_q    <= '0;
      end else begin
         r_wrap     <= w_wrap_next;
         r_lap_pend <= w_lap_set;
         if (clr) begin
            r_holding <= 1'b0;
         end else if (lap) begin
            r_holding <= ~r_holding;
         end
         // The snapshot is taken one edge late: during the pending cycle the live
         // digits already hold the post-edge value, and disp shows them directly.
         if (r_lap_pend) begin
            r_lap_q <= w_digits;
         end
      end
   end

   assign digits  = w_digits;
   assign disp    = (r_holding & ~r_lap_pend) ? r_lap_q : w_digits;
   assign holding = r_holding;
   assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd_chain.sv
// Directed table-driven bench for stopwatch_bcd_chain with default MM:SS moduli,
// plus hand-written asynchronous reset sequences.
module tb_stopwatch_bcd_chain;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic        up_dn = 1'b1;
   logic        load = 1'b0;
   logic [15:0] load_val = '0;
   logic        lap = 1'b0;
   logic [15:0] digits;
   logic [15:0] disp;
   logic        holding;
   logic        wrap;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic        clr;
      logic        load;
      logic [15:0] load_val;
      logic        en;
      logic        up_dn;
      logic        lap;
      int          n;
      logic [15:0] exp_digits;
      logic [15:0] exp_disp;
      logic        exp_holding;
      int          exp_wraps;
   } vec_t;

   vec_t vecs[$];

   stopwatch_bcd_chain dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .clr      (clr),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .lap      (lap),
      .digits   (digits),
      .disp     (disp),
      .holding  (holding),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic c, input logic l,
                               input logic [15:0] lv, input logic e, input logic u,
                               input logic lp, input int n, input logic [15:0] ed,
                               input logic [15:0] edisp, input logic eh, input int ew);
      vec_t v;
      v.name = name; v.clr = c; v.load = l; v.load_val = lv; v.en = e; v.up_dn = u;
      v.lap = lp; v.n = n; v.exp_digits = ed; v.exp_disp = edisp; v.exp_holding = eh;
      v.exp_wraps = ew;
      return v;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int wraps = 0;
      for (int k = 0; k < v.n; k++) begin
         @(negedge clk);
         clr = v.clr; load = v.load; load_val = v.load_val;
         en = v.en; up_dn = v.up_dn; lap = v.lap;
         @(posedge clk);
         #1;
         if (wrap) wraps++;
      end
      clr = 1'b0; load = 1'b0; en = 1'b0; lap = 1'b0;
      $display("vec %0d %s digits=%h disp=%h holding=%b wraps=%0d",
               idx, v.name, digits, disp, holding, wraps);
      check({v.name, ".digits"},  32'(digits),  32'(v.exp_digits));
      check({v.name, ".disp"},    32'(disp),    32'(v.exp_disp));
      check({v.name, ".holding"}, 32'(holding), 32'(v.exp_holding));
      check({v.name, ".wraps"},   32'(wraps),   32'(v.exp_wraps));
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) run_vec(i, vecs[i]);
   endtask

   initial begin
      //                name          clr   load  load_val  en    up    lap   n    digits    disp      hold  wraps
      vecs.push_back(mk("up600",      1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 600, 16'h1000, 16'h1000, 1'b0, 0));
      vecs.push_back(mk("ld5959",     1'b0, 1'b1, 16'h5959, 1'b0, 1'b1, 1'b0, 1,   16'h5959, 16'h5959, 1'b0, 0));
      vecs.push_back(mk("up_wrap",    1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1,   16'h0000, 16'h0000, 1'b0, 1));
      vecs.push_back(mk("after_wrap", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1,   16'h0001, 16'h0001, 1'b0, 0));
      vecs.push_back(mk("clr",        1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1,   16'h0000, 16'h0000, 1'b0, 0));
      vecs.push_back(mk("dn_wrap",    1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1,   16'h5959, 16'h5959, 1'b0, 1));
      vecs.push_back(mk("dn59",       1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 59,  16'h5900, 16'h5900, 1'b0, 0));
      vecs.push_back(mk("ld07A3",     1'b0, 1'b1, 16'h07A3, 1'b0, 1'b1, 1'b0, 1,   16'h0703, 16'h0703, 1'b0, 0));
      vecs.push_back(mk("ldFFFF",     1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1,   16'h0000, 16'h0000, 1'b0, 0));
      vecs.push_back(mk("up12",       1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 12,  16'h0012, 16'h0012, 1'b0, 0));
      vecs.push_back(mk("lap_on",     1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1,   16'h0012, 16'h0012, 1'b1, 0));
      vecs.push_back(mk("up50_held",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 50,  16'h0102, 16'h0012, 1'b1, 0));
      vecs.push_back(mk("lap_off",    1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1,   16'h0102, 16'h0102, 1'b0, 0));
      vecs.push_back(mk("lap_load",   1'b0, 1'b1, 16'h0345, 1'b0, 1'b1, 1'b1, 1,   16'h0345, 16'h0345, 1'b1, 0));
      vecs.push_back(mk("up5_held",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 5,   16'h0350, 16'h0345, 1'b1, 0));
      vecs.push_back(mk("ld0345",     1'b0, 1'b1, 16'h0345, 1'b0, 1'b1, 1'b0, 1,   16'h0345, 16'h0345, 1'b1, 0));
      // index 16: after the mid-cycle reset
      vecs.push_back(mk("first_tick", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1,   16'h0001, 16'h0001, 1'b0, 0));
      vecs.push_back(mk("dir_dn",     1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1,   16'h0000, 16'h0000, 1'b0, 0));
      vecs.push_back(mk("dir_dnwrap", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1,   16'h5959, 16'h5959, 1'b0, 1));
      vecs.push_back(mk("ld1000",     1'b0, 1'b1, 16'h1000, 1'b0, 1'b1, 1'b0, 1,   16'h1000, 16'h1000, 1'b0, 0));
      vecs.push_back(mk("dn_borrow",  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1,   16'h0959, 16'h0959, 1'b0, 0));
      vecs.push_back(mk("ld0059",     1'b0, 1'b1, 16'h0059, 1'b0, 1'b1, 1'b0, 1,   16'h0059, 16'h0059, 1'b0, 0));
      vecs.push_back(mk("up_carry",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1,   16'h0100, 16'h0100, 1'b0, 0));
      vecs.push_back(mk("prio_all",   1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 1,   16'h0000, 16'h0000, 1'b0, 0));
      vecs.push_back(mk("lap_cnt",    1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1,   16'h0001, 16'h0001, 1'b1, 0));
      vecs.push_back(mk("up2_held",   1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2,   16'h0003, 16'h0001, 1'b1, 0));
      vecs.push_back(mk("clr_held",   1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1,   16'h0000, 16'h0000, 1'b0, 0));
   end

   initial begin
      #12;
      check("rst.digits",  32'(digits),  32'h0);
      check("rst.disp",    32'(disp),    32'h0);
      check("rst.holding", 32'(holding), 32'h0);
      check("rst.wrap",    32'(wrap),    32'h0);
      $display("reset state digits=%h disp=%h holding=%b wrap=%b", digits, disp, holding, wrap);
      @(negedge clk);
      reset = 1'b0;

      run_range(0, 15);

      // Asynchronous reset between edges while holding at 0345.
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      $display("async reset at 0345 digits=%h disp=%h holding=%b wrap=%b", digits, disp, holding, wrap);
      check("areset1.digits",  32'(digits),  32'h0);
      check("areset1.disp",    32'(disp),    32'h0);
      check("areset1.holding", 32'(holding), 32'h0);
      #1 reset = 1'b0;

      run_range(16, 26);

      // Down-wrap with lap on the same edge, then reset while wrap is high.
      @(negedge clk);
      en = 1'b1; up_dn = 1'b0; lap = 1'b1;
      @(posedge clk);
      #1;
      $display("down wrap with lap digits=%h disp=%h holding=%b wrap=%b", digits, disp, holding, wrap);
      check("wraplap.digits",  32'(digits),  32'h5959);
      check("wraplap.disp",    32'(disp),    32'h5959);
      check("wraplap.holding", 32'(holding), 32'h1);
      check("wraplap.wrap",    32'(wrap),    32'h1);
      en = 1'b0; lap = 1'b0; up_dn = 1'b1;
      #1 reset = 1'b1;
      #1;
      $display("async reset during wrap digits=%h disp=%h holding=%b wrap=%b", digits, disp, holding, wrap);
      check("areset2.digits",  32'(digits),  32'h0);
      check("areset2.disp",    32'(disp),    32'h0);
      check("areset2.holding", 32'(holding), 32'h0);
      check("areset2.wrap",    32'(wrap),    32'h0);
      #1 reset = 1'b0;

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stopwatch_bcd_chain.md
# stopwatch_bcd_chain

Parametrised cascade of BCD digit counters with a per-digit modulus, forming the time base for stopwatch displays (e.g. MM:SS with digit moduli 10/6/10/6). Adds count direction, synchronous clear, parallel load, a lap/hold display register and a wrap indication on top of the fixed four-digit up-counter. It sits between the tick generator, which drives `en`, and the seven-segment multiplexer, which reads `disp`.

## Interface
- `NUM_DIGITS`, default 4: digit count, range 1..8; digit 0 is least significant.
- `DIGIT_MODS`, default `{4'd6,4'd10,4'd6,4'd10}`: packed `4*NUM_DIGITS` vector; nibble i is the modulus of digit i, legal range 2..10.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: count tick; one step per cycle in which it is high.
- `clr` in 1: synchronous clear of count and hold.
- `up_dn` in 1: direction; 1 counts up, 0 counts down.
- `load` in 1: synchronous parallel load.
- `load_val` in `4*NUM_DIGITS`: value for parallel load.
- `lap` in 1: single-cycle pulse that toggles the hold state.
- `digits` out `4*NUM_DIGITS`: running count, registered.
- `disp` out `4*NUM_DIGITS`: display value; equals `lap_q` when holding, otherwise `digits`.
- `holding` out 1: hold state is active.
- `wrap` out 1: registered one-cycle pulse on a whole-chain wrap.

## Operation
- Priority per edge: `reset` > `clr` > `load` > count (`en`). The `lap` input is evaluated independently, except that `clr` forces hold off.
- Count up (`up_dn`=1, `en`=1):
  - Digit 0 always steps. Digit i steps when every lower digit is at `MOD[j]-1`.
  - A digit at `MOD-1` that steps goes to 0.
- Count down (`up_dn`=0, `en`=1):
  - Digit i steps when every lower digit is at 0.
  - A digit at 0 that steps goes to `MOD-1`.
- Carry and borrow logic is combinational across the whole chain. All digits update on the same edge, with no ripple delay.
- `wrap` is set for one cycle after the edge on which:
  - counting up, all digits were at `MOD-1` and the chain went to all zero; or
  - counting down, all digits were 0 and the chain went to all `MOD-1`.
- Load:
  - Each nibble i of `load_val` that is below `MOD[i]` is stored as given.
  - A nibble at or above `MOD[i]` is stored as 0.
  - `load` never produces `wrap`.
- `clr` sets `digits` to 0 and `holding` to 0, and produces no `wrap`.
- `lap` pulse while not holding: `lap_q` captures the post-edge value of `digits`, i.e. the value including any count or load on that same edge, and `holding` goes to 1.
- `lap` pulse while holding: `holding` goes to 0 and `disp` follows `digits` again.
- Counting continues regardless of the hold state.
- `en` with `up_dn` changing between cycles is legal; the direction is sampled every cycle.

## Timing
- Reset values: `digits`=0, `lap_q`=0, `disp`=0, `holding`=0, `wrap`=0.
- Latency:
  - `en`, `load` and `clr` to `digits`: 1 cycle.
  - `lap` to `disp` frozen: 1 cycle.
  - `disp` is a combinational mux of registers, with no added latency.
- `wrap` is high in exactly the cycle following the wrapping edge. With `en` held high, consecutive wraps are at least `prod(MOD)` cycles apart.
- `reset` asserted mid-count clears all state immediately, without a clock. Release is synchronised by the integrator; the first count follows the first edge with `en`=1 after release.
- `lap` and `clr` on the same edge: `clr` wins and `holding`=0.
- `lap` and `load` on the same edge: `lap_q` captures the loaded value.

## Structure
- `stopwatch_pkg` contains:
  - `typedef logic [3:0] bcd_digit_t`;
  - the default moduli constant `SW_MMSS_MODS`;
  - the function `mod_of(mods, i)` returning nibble i.
- Sub-module `bcd_mod_digit`:
  - one digit with parameter `MOD`;
  - inputs `step`, `up_dn`, `clr`, `load`, `load_d`;
  - outputs `q`, `at_max`, `at_zero`.
- The top module generates `NUM_DIGITS` instances and builds the prefix-AND step chain, the lap register and the `wrap` register.

## Test plan
All scenarios use the default parameters.
- **Up-count:** reset, `up_dn`=1, `en`=1 for 600 cycles -> `digits`=16'h1000, `wrap` never asserted.
- **Full up-wrap:** `load` 16'h5959, then 1 tick up -> `digits`=16'h0000 and `wrap`=1 for exactly one cycle.
- **Down-wrap:** from reset, 1 tick with `up_dn`=0 -> `digits`=16'h5959, `wrap` pulses. A further 59 down ticks -> 16'h5900.
- **Load sanitising:** `load` 16'h07A3 -> `digits`=16'h0703. `load` 16'hFFFF -> 16'h0000, with no `wrap`.
- **Lap hold:**
  - count to 16'h0012, then `lap` with `en`=0 -> `holding`=1;
  - 50 further ticks -> `disp`=16'h0012 while `digits`=16'h0102;
  - a second `lap` -> `disp`=16'h0102.
- **Priority and reset:** `clr`, `load` and `en` in the same cycle -> 16'h0000 and `holding`=0. Asynchronous `reset` pulse between clock edges at 16'h0345 -> all outputs 0 before the next edge.
